// File: rtl/instr_fetch.sv
// Instruction-fetch sequencer: captures the PC on start, reads one word from
// instruction memory over a req/ack handshake, then presents PC+1 with a load pulse.
module instr_fetch #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [31:0]       pc_q,
    output logic [31:0]       pc_d,
    output logic              pc_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ack,
    input  logic [31:0]       mem_data,
    output logic [31:0]       ir,
    output logic              ir_valid,
    output logic              busy,
    output logic              fault
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        shadow_q, shadow_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               rd_q, rd_d;
    logic [31:0]        ir_q, ir_d;
    logic               irv_q, irv_d;
    logic [31:0]        pcn_q, pcn_d;
    logic               pcen_q, pcen_d;
    logic               busy_q, busy_d;
    logic               fault_q, fault_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= S_IDLE;
            shadow_q <= '0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            ir_q     <= '0;
            irv_q    <= 1'b0;
            pcn_q    <= '0;
            pcen_q   <= 1'b0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            ir_q     <= ir_d;
            irv_q    <= irv_d;
            pcn_q    <= pcn_d;
            pcen_q   <= pcen_d;
            busy_q   <= busy_d;
            fault_q  <= fault_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        addr_d   = addr_q;
        rd_d     = rd_q;
        ir_d     = ir_q;
        irv_d    = irv_q;
        pcn_d    = pcn_q;
        pcen_d   = pcen_q;
        busy_d   = busy_q;
        fault_d  = fault_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shadow_d = pc_q;
                    addr_d   = pc_q[ADDR_W-1:0];
                    busy_d   = 1'b1;
                    fault_d  = 1'b0;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                rd_d    = 1'b1;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // An ack on the final counted cycle still completes the fetch.
                if (mem_ack) begin
                    ir_d    = mem_data;
                    irv_d   = 1'b1;
                    pcn_d   = shadow_q + 32'd1;
                    pcen_d  = 1'b1;
                    rd_d    = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rd_d    = 1'b0;
                    fault_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                irv_d   = 1'b0;
                pcen_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pc_d     = pcn_q;
    assign pc_en    = pcen_q;
    assign mem_addr = addr_q;
    assign mem_rd   = rd_q;
    assign ir       = ir_q;
    assign ir_valid = irv_q;
    assign busy     = busy_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: the driver predicts each fetch outcome from the
// ack delay and PC, and a monitor checks it when ir_valid or a new fault appears.
module tb_instr_fetch;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        clr, start, mem_ack;
    logic [31:0] pc_q, mem_data;
    logic [31:0] pc_d, ir;
    logic [8:0]  mem_addr;
    logic        pc_en, mem_rd, ir_valid, busy, fault;

    instr_fetch #(.ADDR_W(9), .TIMEOUT(TMO)) dut (
        .clk(clk), .clr(clr), .start(start), .pc_q(pc_q), .pc_d(pc_d),
        .pc_en(pc_en), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack),
        .mem_data(mem_data), .ir(ir), .ir_valid(ir_valid), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ok;
        logic [31:0] ir;
        logic [31:0] pcd;
        logic [31:0] addr;
        int          rd;
        int          bsy;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] last_ir = 0;
    logic [31:0] last_pcd = 0;
    logic        clr_pe = 1'b0;
    int          rd_cnt = 0, busy_cnt = 0;
    bit          post = 0;
    logic        fault_prev = 1'b0;

    always @(posedge clk) begin
        cyc++;
        clr_pe <= clr;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc_d"}, pc_d, 0);
        chk({tag, "_pc_en"}, pc_en, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_rd"}, mem_rd, 0);
        chk({tag, "_ir"}, ir, 0);
        chk({tag, "_ir_valid"}, ir_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fault"}, fault, 0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        chk("idle_wait", busy, 0);
    endtask

    // One fetch; ack asserted d wait cycles after mem_rd rises (d >= TMO means never).
    task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data, input int d);
        exp_t e;
        wait_idle();
        e.addr = pc & 32'h1FF;
        if (d < TMO) begin
            e.ok = 1; e.ir = data; e.pcd = pc + 32'd1; e.rd = d + 1; e.bsy = d + 3;
            last_ir = data; last_pcd = pc + 32'd1;
        end else begin
            e.ok = 0; e.ir = last_ir; e.pcd = last_pcd; e.rd = TMO; e.bsy = TMO + 1;
        end
        q.push_back(e);
        pc_q = pc; start = 1; mem_ack = 1'($urandom_range(0, 1)); mem_data = $urandom;
        @(negedge clk);
        start = 0;
        chk("busy_on_start", busy, 1);
        chk("fault_cleared_by_start", fault, 0);
        chk("addr_after_start", mem_addr, e.addr);
        pc_q = $urandom; mem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        mem_ack = 0;
        chk("rd_raised", mem_rd, 1);
        if (d < TMO) begin
            repeat (d) @(negedge clk);
            mem_data = data; mem_ack = 1;
            @(negedge clk);
            mem_ack = 0; mem_data = $urandom;
        end else begin
            repeat (TMO) @(negedge clk);
            chk("rd_dropped_on_timeout", mem_rd, 0);
        end
    endtask

    always @(negedge clk) begin
        if (clr_pe) begin
            rd_cnt = 0; busy_cnt = 0; post = 0; fault_prev = fault;
        end else begin
            if (post) begin
                chk("busy_after_done", busy, 0);
                chk("pulses_after_done", {pc_en, ir_valid}, 0);
                post = 0;
            end
            if (mem_rd) rd_cnt++;
            if (busy) busy_cnt++;
            if (pc_en !== ir_valid) chk("pc_en_with_ir_valid", pc_en, ir_valid);
            if (ir_valid || (fault && !fault_prev)) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_event ir_valid=%b fault=%b with nothing expected", ir_valid, fault);
                end else begin
                    mon_e = q.pop_front();
                    chk("outcome_ok", ir_valid, mon_e.ok);
                    chk("ir", ir, mon_e.ir);
                    chk("pc_d", pc_d, mon_e.pcd);
                    chk("mem_addr", mem_addr, mon_e.addr);
                    chk("mem_rd_cycles", rd_cnt, mon_e.rd);
                    chk("busy_cycles", busy_cnt, mon_e.bsy);
                    chk("fault_flag", fault, !mon_e.ok);
                end
                post = ir_valid;
                rd_cnt = 0; busy_cnt = 0;
            end
            fault_prev = fault;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_rise;
        exp_t e;
        clr = 1; start = 0; mem_ack = 0; pc_q = 0; mem_data = 0;
        repeat (2) @(negedge clk);
        chk_reset("reset");
        clr = 0;
        @(negedge clk);

        do_fetch(32'h0000_0010, 32'hDEAD_BEEF, 2);
        do_fetch(32'hFFFF_FFFF, 32'h1234_5678, 0);
        do_fetch(32'h0000_0ABC, 32'h5555_AAAA, 99);
        do_fetch(32'h0000_0100, 32'hCAFE_F00D, TMO - 1);
        do_fetch(32'h0000_0200, 32'h0BAD_F00D, 99);
        do_fetch(32'h0000_0201, 32'h7777_0001, 1);

        // Reset mid-fetch on the third wait cycle, then a stray ack.
        wait_idle();
        pc_q = 32'h0000_0033; start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        repeat (2) @(negedge clk);
        clr = 1;
        @(negedge clk);
        clr = 0;
        chk_reset("clr_mid_fetch");
        last_ir = 0; last_pcd = 0;
        mem_ack = 1; mem_data = 32'hFFFF_0000;
        @(negedge clk);
        mem_ack = 0;
        repeat (2) begin
            @(negedge clk);
            chk("post_clr_rd", mem_rd, 0);
            chk("post_clr_busy", busy, 0);
            chk("post_clr_ir", ir, 0);
        end

        // start held high: one fetch accepted every 4 cycles.
        wait_idle();
        pc_q = 32'h0000_0444; start = 1;
        prev_rise = 0;
        for (int j = 0; j < 4; j++) begin
            e.ok = 1; e.ir = $urandom; e.pcd = 32'h0000_0445; e.addr = 32'h044;
            e.rd = 1; e.bsy = 3;
            last_ir = e.ir; last_pcd = e.pcd;
            q.push_back(e);
            for (int k = 0; k < 10 && !mem_rd; k++) @(negedge clk);
            chk("b2b_rd_seen", mem_rd, 1);
            if (j > 0) chk("b2b_period", cyc - prev_rise, 4);
            prev_rise = cyc;
            mem_data = e.ir; mem_ack = 1;
            @(negedge clk);
            mem_ack = 0;
        end
        start = 0;

        for (int n = 0; n < 30; n++)
            do_fetch($urandom, $urandom, int'($urandom_range(0, 5)));

        wait_idle();
        repeat (4) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
